mod_audio_adc_deser: RTL and testbench

Serial receiver for the codec ADC path, the capture-side counterpart of the DAC serial driver. It deserializes left-justified stereo samples from AUD_ADCDAT, framed by AUD_ADCLRCK and clocked by AUD_BCLK. It presents one packed {left,right} word per frame with a single-cycle valid strobe to downstream DSP logic. It runs entirely in the i_aud_bclk domain; any crossing into the system clock domain is the consumer's responsibility.

---
 rtl/mod_audio_pkg.sv | 16 +
 rtl/mod_audio_lrck_edge.sv | 22 ++
 rtl/mod_audio_adc_deser.sv | 113 +++++++++++
 tb/tb_mod_audio_adc_deser.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_audio_pkg.sv
// Shared audio codec constants: FSM encodings and frame widths.
// Used by the ADC deserializer and the DAC serial driver.
package mod_audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 16;
  localparam int AUDIO_FRAME_WIDTH  = 2 * AUDIO_SAMPLE_WIDTH;

  localparam logic [3:0] ST_SYNC  = 4'd0;
  localparam logic [3:0] ST_LEFT  = 4'd1;
  localparam logic [3:0] ST_RIGHT = 4'd2;

  function automatic int frame_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mod_audio_lrck_edge.sv
// LRCK edge detector: registers lrck (reset high) and flags edges.
// Ports: clk, nrst, lrck in; rise, fall out (combinational).
module mod_audio_lrck_edge (
  input  logic clk,
  input  logic nrst,
  input  logic lrck,
  output logic rise,
  output logic fall
);

  logic lrck_q;

  // Reset high so an LRCK already high at release is not a frame start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) lrck_q <= 1'b1;
    else       lrck_q <= lrck;
  end

  assign rise = lrck & ~lrck_q;
  assign fall = ~lrck & lrck_q;

endmodule

// File: rtl/mod_audio_adc_deser.sv
// Left-justified stereo ADC deserializer in the bclk domain.
// Ports: i_aud_bclk, i_nrst, i_aud_adclrck, i_aud_adcdat in;
// o_data {left,right}, o_valid, o_err strobes, o_state debug out.
module mod_audio_adc_deser
  import mod_audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_SAMPLE_WIDTH
) (
  input  logic                            i_aud_bclk,
  input  logic                            i_nrst,
  input  logic                            i_aud_adclrck,
  input  logic                            i_aud_adcdat,
  output logic [frame_w(DATA_WIDTH)-1:0]  o_data,
  output logic                            o_valid,
  output logic                            o_err,
  output logic [3:0]                      o_state
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

  logic [3:0]            state, state_d;
  logic                  rise, fall;
  logic [DATA_WIDTH-1:0] sr, left_hold;
  logic [CW-1:0]         cnt;
  logic                  full;
  logic                  start, shift_en, latch_left;
  logic                  valid_d, err_d;

  mod_audio_lrck_edge u_edge (
    .clk  (i_aud_bclk),
    .nrst (i_nrst),
    .lrck (i_aud_adclrck),
    .rise (rise),
    .fall (fall)
  );

  assign full = (cnt == FULL);

  always_ff @(posedge i_aud_bclk or negedge i_nrst) begin
    if (!i_nrst) state <= ST_SYNC;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_SYNC:  if (rise) state_d = ST_LEFT;
      ST_LEFT:  if (fall) state_d = full ? ST_RIGHT : ST_SYNC;
      ST_RIGHT: if (rise) state_d = ST_LEFT;
      default:  state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    shift_en   = 1'b0;
    latch_left = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state)
      ST_SYNC: start = rise;
      ST_LEFT: begin
        latch_left = fall & full;
        start      = fall & full;
        err_d      = fall & ~full;
        shift_en   = ~fall & ~full;
      end
      ST_RIGHT: begin
        // A rise always opens a new left half, even after a short right.
        start    = rise;
        valid_d  = rise & full;
        err_d    = rise & ~full;
        shift_en = ~rise & ~full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_aud_bclk or negedge i_nrst) begin
    if (!i_nrst) begin
      sr        <= '0;
      cnt       <= '0;
      left_hold <= '0;
    end else begin
      if (start) begin
        sr  <= DATA_WIDTH'(i_aud_adcdat);
        cnt <= CW'(1);
      end else if (shift_en) begin
        sr  <= (sr << 1) | DATA_WIDTH'(i_aud_adcdat);
        cnt <= cnt + CW'(1);
      end else if (state_d == ST_SYNC) begin
        cnt <= '0;
      end
      if (latch_left) left_hold <= sr;
    end
  end

  always_ff @(posedge i_aud_bclk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= valid_d;
      o_err   <= err_d;
      if (valid_d) o_data <= {left_hold, sr};
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_mod_audio_adc_deser.sv
// Directed bench for mod_audio_adc_deser, DATA_WIDTH=16.
// 32 bclk per LRCK half; inputs driven on falling edges.
module tb_mod_audio_adc_deser;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        lrck = 1'b0;
  logic        dat = 1'b0;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_err;
  logic [3:0]  o_state;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          vcnt = 0;
  int          ecnt = 0;
  int          both = 0;
  int          runlen = 0;
  int          maxrun = 0;
  logic [31:0] vdata[$];
  int          vcyc[$];

  mod_audio_adc_deser #(.DATA_WIDTH(16)) dut (
    .i_aud_bclk    (clk),
    .i_nrst        (nrst),
    .i_aud_adclrck (lrck),
    .i_aud_adcdat  (dat),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_err         (o_err),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (o_valid) begin
      vcnt++;
      vdata.push_back(o_data);
      vcyc.push_back(cyc);
      runlen++;
      if (runlen > maxrun) maxrun = runlen;
    end else begin
      runlen = 0;
    end
    if (o_err) ecnt++;
    if (o_valid && o_err) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    vcnt = 0;
    ecnt = 0;
    both = 0;
    maxrun = 0;
    vdata.delete();
    vcyc.delete();
  endtask

  task automatic do_reset(input logic lr);
    @(negedge clk);
    nrst = 1'b0;
    lrck = lr;
    dat  = 1'b0;
    repeat (3) @(negedge clk);
    #1 clr();
    nrst = 1'b1;
  endtask

  task automatic send_half(input logic lr, input logic [15:0] w,
                           input int nb, input logic fill,
                           input int tot);
    for (int i = 0; i < tot; i++) begin
      @(negedge clk);
      lrck = lr;
      dat  = (i < nb) ? w[nb-1-i] : fill;
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input logic fill);
    send_half(1'b1, l, 16, fill, 32);
    send_half(1'b0, r, 16, fill, 32);
  endtask

  task automatic close_frame();
    send_half(1'b1, 16'h0, 0, 1'b0, 3);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    #1;
    chk("rst_data", o_data, 32'h0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    chk("rst_state", {28'b0, o_state}, 32'd0);

    // basic frame
    do_reset(1'b0);
    send_half(1'b0, 16'h0, 0, 1'b0, 4);
    send_half(1'b1, 16'hA5C3, 16, 1'b0, 16);
    #1 chk("f1_st_left", {28'b0, o_state}, 32'd1);
    send_half(1'b1, 16'h0, 0, 1'b0, 16);
    send_half(1'b0, 16'h1234, 16, 1'b0, 16);
    #1 chk("f1_st_right", {28'b0, o_state}, 32'd2);
    send_half(1'b0, 16'h0, 0, 1'b0, 16);
    close_frame();
    chk("f1_vcnt", vcnt, 32'd1);
    chk("f1_data", o_data, 32'hA5C31234);
    chk("f1_pulse", maxrun, 32'd1);
    chk("f1_st_end", {28'b0, o_state}, 32'd1);

    // reset release with LRCK high, mid-left
    do_reset(1'b1);
    send_half(1'b1, 16'hFFFF, 16, 1'b1, 20);
    send_half(1'b0, 16'h0001, 16, 1'b0, 32);
    #1 chk("rl_sync", {28'b0, o_state}, 32'd0);
    frame(16'hFFFF, 16'h0001, 1'b0);
    close_frame();
    chk("rl_vcnt", vcnt, 32'd1);
    chk("rl_data", o_data, 32'hFFFF0001);

    // trailing bits ignored
    do_reset(1'b0);
    send_half(1'b0, 16'h0, 0, 1'b0, 4);
    frame(16'h8001, 16'h8001, 1'b1);
    close_frame();
    chk("tr_vcnt", vcnt, 32'd1);
    chk("tr_data", o_data, 32'h80018001);

    // short left half
    do_reset(1'b0);
    send_half(1'b0, 16'h0, 0, 1'b0, 4);
    send_half(1'b1, 16'hFFFF, 16, 1'b0, 10);
    send_half(1'b0, 16'h0, 0, 1'b0, 4);
    #1 chk("sl_state", {28'b0, o_state}, 32'd0);
    chk("sl_ecnt", ecnt, 32'd1);
    chk("sl_vcnt0", vcnt, 32'd0);
    send_half(1'b0, 16'h0, 0, 1'b0, 28);
    frame(16'h00FF, 16'hFF00, 1'b0);
    close_frame();
    chk("sl_vcnt", vcnt, 32'd1);
    chk("sl_data", o_data, 32'h00FFFF00);

    // short right half
    do_reset(1'b0);
    send_half(1'b0, 16'h0, 0, 1'b0, 4);
    frame(16'h1111, 16'h2222, 1'b0);
    send_half(1'b1, 16'h3333, 16, 1'b0, 32);
    send_half(1'b0, 16'h2AAA, 16, 1'b0, 8);
    send_half(1'b1, 16'h4444, 16, 1'b0, 32);
    #1 chk("sr_ecnt", ecnt, 32'd1);
    chk("sr_vcnt", vcnt, 32'd1);
    chk("sr_hold", o_data, 32'h11112222);
    chk("sr_state", {28'b0, o_state}, 32'd1);
    send_half(1'b0, 16'h5555, 16, 1'b0, 32);
    close_frame();
    chk("sr_vcnt2", vcnt, 32'd2);
    chk("sr_data", o_data, 32'h44445555);

    // back-to-back frames and mid-frame reset
    do_reset(1'b0);
    send_half(1'b0, 16'h0, 0, 1'b0, 4);
    frame(16'h0102, 16'h0304, 1'b0);
    frame(16'hBEEF, 16'hCAFE, 1'b0);
    frame(16'h7FFF, 16'h8000, 1'b1);
    frame(16'h1357, 16'h2468, 1'b0);
    send_half(1'b1, 16'hDEAD, 16, 1'b0, 32);
    send_half(1'b0, 16'hFFFF, 16, 1'b0, 10);
    #1 chk("bb_vcnt", vcnt, 32'd4);
    if (vcnt == 4) begin
      chk("bb_d0", vdata[0], 32'h01020304);
      chk("bb_d1", vdata[1], 32'hBEEFCAFE);
      chk("bb_d2", vdata[2], 32'h7FFF8000);
      chk("bb_d3", vdata[3], 32'h13572468);
      for (int i = 0; i < 3; i++)
        chk("bb_gap", vcyc[i+1] - vcyc[i], 32'd64);
    end
    @(negedge clk);
    nrst = 1'b0;
    #1 chk("mr_data", o_data, 32'h0);
    chk("mr_state", {28'b0, o_state}, 32'd0);
    chk("mr_flags", {30'b0, o_valid, o_err}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    send_half(1'b0, 16'h0, 0, 1'b1, 19);
    frame(16'h0F0F, 16'hF0F0, 1'b0);
    close_frame();
    chk("mr_vcnt", vcnt, 32'd5);
    chk("mr_data2", o_data, 32'h0F0FF0F0);
    chk("mr_ecnt", ecnt, 32'd0);
    chk("excl", both, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
